spike_rate_decoder: RTL and testbench



---
 rtl/snn_decoder_pkg.sv | 19 +
 rtl/spike_sat_counter.sv | 30 +++
 rtl/spike_rate_decoder.sv | 122 ++++++++++++
 tb/tb_spike_rate_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/snn_decoder_pkg.sv
// Shared definitions for the spike rate decoder: FSM state encoding and
// a constant clog2 used to size the window position counter.
package snn_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    UPDATE = 2'd2
  } dec_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// Saturating spike accumulator. Synchronous clear wins over increment; the
// overflow flag is sticky until cleared.
module spike_sat_counter #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   ovf
);

  localparam logic [COUNT_WIDTH-1:0] MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (count == MAX) ovf   <= 1'b1;
      else              count <= count + ONE;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes over fixed windows and turns the count into a latched LED
// level with on/off hysteresis. Define SPIKE_EDGE_COUNT_EN to count rising
// edges of spike_in instead of high cycles.
module spike_rate_decoder
  import snn_decoder_pkg::*;
#(
  parameter int WINDOW        = 64,
  parameter int COUNT_WIDTH   = 8,
  parameter int ON_THRESHOLD  = 3,
  parameter int OFF_THRESHOLD = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   spike_in,
  output logic                   level_out,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   window_done,
  output logic                   overflow
);

  localparam int                     WCNT_W = clog2(WINDOW);
  localparam logic [WCNT_W-1:0]      WLAST  = WCNT_W'(WINDOW - 1);
  localparam logic [WCNT_W-1:0]      WONE   = WCNT_W'(1);
  localparam logic [COUNT_WIDTH-1:0] ON_T   = COUNT_WIDTH'(ON_THRESHOLD);
  localparam logic [COUNT_WIDTH-1:0] OFF_T  = COUNT_WIDTH'(OFF_THRESHOLD);

  dec_state_e             state;
  logic [WCNT_W-1:0]      wcnt;
  logic [COUNT_WIDTH-1:0] acc;
  logic                   acc_ovf;
  logic                   spike_ev;
  logic                   acc_clr;
  logic                   acc_inc;

`ifdef SPIKE_EDGE_COUNT_EN
  logic spike_prev;

  // Tracks spike_in in every state so a level held across a window
  // boundary is not re-counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     spike_prev <= 1'b0;
    else if (clear) spike_prev <= 1'b0;
    else            spike_prev <= spike_in;
  end

  assign spike_ev = spike_in & ~spike_prev;
`else
  assign spike_ev = spike_in;
`endif

  // Accumulator restarts on window start, update, abort and clear.
  assign acc_clr = clear
                 | (state == IDLE   &&  enable)
                 | (state == COUNT  && !enable)
                 | (state == UPDATE);
  assign acc_inc = (state == COUNT) && enable && spike_ev;

  spike_sat_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .inc   (acc_inc),
    .count (acc),
    .ovf   (acc_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wcnt        <= '0;
      level_out   <= 1'b0;
      count_out   <= '0;
      window_done <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        wcnt      <= '0;
        level_out <= 1'b0;
        count_out <= '0;
        overflow  <= 1'b0;
      end else if (!enable && state == COUNT) begin
        state <= IDLE;
        wcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (enable) begin
              state <= COUNT;
              wcnt  <= '0;
            end
          end
          COUNT: begin
            if (wcnt == WLAST) begin
              state <= UPDATE;
              wcnt  <= '0;
            end else begin
              wcnt <= wcnt + WONE;
            end
          end
          UPDATE: begin
            count_out   <= acc;
            overflow    <= acc_ovf;
            window_done <= 1'b1;
            wcnt        <= '0;
            // Between the thresholds the previous level is kept.
            if (acc >= ON_T)       level_out <= 1'b1;
            else if (acc <= OFF_T) level_out <= 1'b0;
            state <= enable ? COUNT : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: three instances with different
// window/width settings, a per-cycle window model and literal checkpoints.
module tb_spike_rate_decoder;

`ifdef SPIKE_EDGE_COUNT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  localparam int ON  = 3;
  localparam int OFF = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] en = '0, clr = '0, spk = '0;
  logic [2:0] lvl, done, ovf;
  logic [7:0] cnt_a, cnt_b;
  logic [2:0] cnt_c;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW(8), .COUNT_WIDTH(8), .ON_THRESHOLD(ON), .OFF_THRESHOLD(OFF)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .clear(clr[0]), .spike_in(spk[0]),
    .level_out(lvl[0]), .count_out(cnt_a), .window_done(done[0]), .overflow(ovf[0]));
  spike_rate_decoder #(.WINDOW(12), .COUNT_WIDTH(8), .ON_THRESHOLD(ON), .OFF_THRESHOLD(OFF)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .clear(clr[1]), .spike_in(spk[1]),
    .level_out(lvl[1]), .count_out(cnt_b), .window_done(done[1]), .overflow(ovf[1]));
  spike_rate_decoder #(.WINDOW(16), .COUNT_WIDTH(3), .ON_THRESHOLD(ON), .OFF_THRESHOLD(OFF)) u_c (
    .clk(clk), .rst_n(rst_n), .enable(en[2]), .clear(clr[2]), .spike_in(spk[2]),
    .level_out(lvl[2]), .count_out(cnt_c), .window_done(done[2]), .overflow(ovf[2]));

  function automatic int win(input int d);
    return (d == 0) ? 8 : (d == 1) ? 12 : 16;
  endfunction
  function automatic int maxc(input int d);
    return (d == 2) ? 7 : 255;
  endfunction
  function automatic int sat(input int a, input int d);
    return (a > maxc(d)) ? maxc(d) : a;
  endfunction
  function automatic int dut_cnt(input int d);
    return (d == 0) ? int'(cnt_a) : (d == 1) ? int'(cnt_b) : int'(cnt_c);
  endfunction
  function automatic int ev(input bit s, input bit p);
    return EDGE ? int'(s & ~p) : int'(s);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Window model: position -1 = idle, 0..W-1 = sampling, W = update cycle.
  // The spike tally is unbounded; saturation is applied when it is reported.
  int mpos[3], macc[3], m_cnt[3];
  bit mprev[3], m_lvl[3], m_done[3], m_ovf[3];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n || clr[d]) begin
        mpos[d] <= -1; macc[d] <= 0; mprev[d] <= 1'b0;
        m_lvl[d] <= 1'b0; m_cnt[d] <= 0; m_done[d] <= 1'b0; m_ovf[d] <= 1'b0;
      end else begin
        m_done[d] <= 1'b0;
        mprev[d]  <= spk[d];
        if (mpos[d] < 0) begin
          if (en[d]) begin mpos[d] <= 0; macc[d] <= 0; end
        end else if (mpos[d] == win(d)) begin
          m_cnt[d]  <= sat(macc[d], d);
          m_ovf[d]  <= macc[d] > maxc(d);
          if (sat(macc[d], d) >= ON)       m_lvl[d] <= 1'b1;
          else if (sat(macc[d], d) <= OFF) m_lvl[d] <= 1'b0;
          m_done[d] <= 1'b1;
          macc[d]   <= 0;
          mpos[d]   <= en[d] ? 0 : -1;
        end else if (!en[d]) begin
          mpos[d] <= -1; macc[d] <= 0;
        end else begin
          macc[d] <= macc[d] + ev(spk[d], mprev[d]);
          mpos[d] <= mpos[d] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("mdl_lvl[%0d]", d),  int'(lvl[d]),  int'(m_lvl[d]));
        check($sformatf("mdl_cnt[%0d]", d),  dut_cnt(d),    m_cnt[d]);
        check($sformatf("mdl_done[%0d]", d), int'(done[d]), int'(m_done[d]));
        check($sformatf("mdl_ovf[%0d]", d),  int'(ovf[d]),  int'(m_ovf[d]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One window of sampling positions, spike at p%period==0 for p<lim, then
  // the update cycle with spike low.
  task automatic drive_win(input int d, input int period, input int lim);
    for (int p = 0; p < win(d); p++) begin
      spk[d] = (period != 0) && (p % period == 0) && (p < lim);
      step(1);
    end
    spk[d] = 1'b0;
    check("pre_done", int'(done[d]), 0);
    step(1);
  endtask

  task automatic expect_out(input string nm, input int d, input int c, input int l, input int o);
    check({nm, "_done"}, int'(done[d]), 1);
    check({nm, "_cnt"},  dut_cnt(d),    c);
    check({nm, "_lvl"},  int'(lvl[d]),  l);
    check({nm, "_ovf"},  int'(ovf[d]),  o);
  endtask

  int exp1_cnt, exp1_lvl;

  initial begin
    exp1_cnt = EDGE ? 0 : 8;
    exp1_lvl = EDGE ? 0 : 1;
    @(negedge clk);
    chk_on = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check("rst_lvl",  int'(lvl[d]),  0);
      check("rst_cnt",  dut_cnt(d),    0);
      check("rst_done", int'(done[d]), 0);
      check("rst_ovf",  int'(ovf[d]),  0);
    end
    rst_n = 1'b1;
    step(1);

    // Hysteresis, W=12
    en[1] = 1'b1; step(1);
    drive_win(1, 2, 12);  expect_out("hys_on",   1, 6, 1, 0);
    drive_win(1, 6, 12);  expect_out("hys_hold", 1, 2, 1, 0);
    drive_win(1, 0, 12);  expect_out("hys_off",  1, 0, 0, 0);
    en[1] = 1'b0; step(2);

    // Saturation, 3-bit counter, W=16
    en[2] = 1'b1; step(1);
    drive_win(2, 2, 16);  expect_out("sat_ovf", 2, 7, 1, 1);
    drive_win(2, 8, 16);  expect_out("sat_rec", 2, 2, 1, 0);
    en[2] = 1'b0; step(2);

    // Full-rate, W=8: update every 9 cycles
    en[0] = 1'b1; spk[0] = 1'b1;
    step(10);  expect_out("full1", 0, exp1_cnt, exp1_lvl, 0);
    step(1);   check("full_pulse", int'(done[0]), 0);
    step(8);   expect_out("full2", 0, exp1_cnt, exp1_lvl, 0);

    // Abort at wcnt=4, then re-enable
    step(4);
    en[0] = 1'b0; spk[0] = 1'b0;
    step(1);
    check("abort_done", int'(done[0]), 0);
    check("abort_cnt",  int'(cnt_a),   exp1_cnt);
    check("abort_lvl",  int'(lvl[0]),  exp1_lvl);
    step(3);
    check("abort_idle_done", int'(done[0]), 0);
    en[0] = 1'b1; step(1);
    drive_win(0, 2, 6);  expect_out("reen", 0, 3, 1, 0);

    // Synchronous clear mid-window
    step(3);
    clr[0] = 1'b1; step(1);
    check("clr_lvl",  int'(lvl[0]),  0);
    check("clr_cnt",  int'(cnt_a),   0);
    check("clr_ovf",  int'(ovf[0]),  0);
    check("clr_done", int'(done[0]), 0);
    clr[0] = 1'b0; step(1);
    drive_win(0, 2, 8);  expect_out("post_clr", 0, 4, 1, 0);

    // Async reset while in the update cycle
    step(8);
    #2 rst_n = 1'b0;
    #1;
    check("arst_lvl",  int'(lvl[0]),  0);
    check("arst_cnt",  int'(cnt_a),   0);
    check("arst_ovf",  int'(ovf[0]),  0);
    check("arst_done", int'(done[0]), 0);
    @(negedge clk);
    rst_n = 1'b1; spk[0] = 1'b0;
    step(1);

    // Spike rises at window position 2 and stays high
    for (int p = 0; p < 8; p++) begin
      spk[0] = (p >= 2);
      step(1);
    end
    step(1);
    expect_out("held", 0, EDGE ? 1 : 6, EDGE ? 0 : 1, 0);
    en[0] = 1'b0; spk[0] = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
